// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
package imem_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_e;

  // Instruction returned for any fetch that cannot read memory (addi x0,x0,0).
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    err_e        err;
    logic [31:0] addr;
  } rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush and extra-bit full/empty pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;
  logic [PW-1:0]    waddr;

  // Next pointers; a push in a flush cycle survives as the only entry at slot 0.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    waddr  = wptr_q[PW-1:0];
    if (i_flush) begin
      rptr_d = '0;
      wptr_d = i_push ? PTR_ONE : '0;
      waddr  = '0;
    end else begin
      if (i_push) wptr_d = wptr_q + PTR_ONE;
      if (i_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage is not reset; validity comes from the pointers alone.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[waddr] <= i_push_data;
  end

  assign o_head  = mem_q[rptr_q[PW-1:0]];
  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign o_count = wptr_q - rptr_q;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory with credit-bounded in-order fetch responses
module imem_responder #(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [31:0]              i_req_addr,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [31:0]              o_rsp_instr,
  output logic [1:0]               o_rsp_err,
  output logic [31:0]              o_rsp_addr,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [31:0]              i_wr_data
);

  import imem_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(FIFO_DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic          accept, pop, push;
  rsp_t          acc_rsp, push_rsp, head_rsp;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic          fifo_unused;

  assign o_req_ready = !i_rst && (outstanding_q < MAX_OUT);
  assign accept      = i_req_valid && o_req_ready;
  assign o_rsp_valid = !fifo_empty;
  assign pop         = o_rsp_valid && i_rsp_ready;

  // Classify the incoming fetch and read the old memory word in the accept cycle.
  always_comb begin
    acc_rsp.addr  = i_req_addr;
    acc_rsp.err   = ERR_NONE;
    acc_rsp.instr = NOP;
    if (i_req_addr[1:0] != 2'b00) begin
      acc_rsp.err = ERR_MISALIGN;
    end else if ({2'b00, i_req_addr[31:2]} >= 32'(DEPTH)) begin
      acc_rsp.err = ERR_RANGE;
    end else begin
      acc_rsp.instr = mem_q[i_req_addr[AW+1:2]];
    end
  end

  // Program-load port, independent of the fetch channels and of flush.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  // Credit count: flush drops everything except a request accepted alongside it.
  always_comb begin
    outstanding_d = outstanding_q;
    if (i_flush) begin
      outstanding_d = {{(CW-1){1'b0}}, accept};
    end else begin
      outstanding_d = outstanding_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, pop};
    end
  end

  // Credit counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) outstanding_q <= '0;
    else       outstanding_q <= outstanding_d;
  end

  if (LATENCY == 1) begin : g_direct
    assign push     = accept;
    assign push_rsp = acc_rsp;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    rsp_t               data_q [LATENCY-1];

    // Delay line; the first stage keeps a flush-cycle accept, later stages are discarded.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_q <= '0;
        for (int i = 0; i < LATENCY-1; i++) data_q[i] <= '0;
      end else begin
        vld_q[0]  <= accept;
        data_q[0] <= acc_rsp;
        for (int i = 1; i < LATENCY-1; i++) begin
          vld_q[i]  <= vld_q[i-1] && !i_flush;
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign push     = vld_q[LATENCY-2] && !i_flush;
    assign push_rsp = data_q[LATENCY-2];
  end

  sync_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_rsp_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (push_rsp),
    .i_pop       (pop),
    .i_flush     (i_flush),
    .o_head      (head_rsp),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  // The credit counter already bounds occupancy, so full/count are informational.
  assign fifo_unused = ^{fifo_full, fifo_count};

  assign o_rsp_instr = fifo_empty ? 32'h0 : head_rsp.instr;
  assign o_rsp_err   = fifo_empty ? ERR_NONE : head_rsp.err;
  assign o_rsp_addr  = fifo_empty ? 32'h0 : head_rsp.addr;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized and directed checks against a queue-based model
module tb_imem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int FD    = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic [1:0]    rsp_err;
  logic [31:0]   rsp_addr;
  logic          flush;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  int n_checks = 0;
  int n_pass   = 0;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_instr (rsp_instr),
    .o_rsp_err   (rsp_err),
    .o_rsp_addr  (rsp_addr),
    .i_flush     (flush),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected responses in acceptance order, each with the cycle it may appear.
  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
    logic [31:0] addr;
    longint      due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  longint      cyc = 0;

  function automatic exp_t model_fetch(input logic [31:0] a, input longint now);
    exp_t e;
    e.addr  = a;
    e.due   = now + LAT;
    e.instr = 32'h0000_0013;
    if (a % 4 != 0)           e.err = 2'd1;
    else if (a / 4 >= DEPTH)  e.err = 2'd2;
    else begin
      e.err   = 2'd0;
      e.instr = mem_m[a / 4];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    logic exp_ready, exp_valid;
    if (rst) begin
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_instr", rsp_instr, 32'd0);
      chk("rst_rsp_err",   {30'b0, rsp_err}, 32'd0);
      chk("rst_rsp_addr",  rsp_addr, 32'd0);
      q.delete();
    end else begin
      exp_ready = (q.size() < FD);
      exp_valid = (q.size() > 0) && (q[0].due <= cyc);
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("rsp_instr", rsp_instr, q[0].instr);
        chk("rsp_err",   {30'b0, rsp_err}, {30'b0, q[0].err});
        chk("rsp_addr",  rsp_addr, q[0].addr);
        if (rsp_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
      if (req_valid && exp_ready) q.push_back(model_fetch(req_addr, cyc));
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      req_valid = 1'b0;
      wr_en     = 1'b0;
      flush     = 1'b0;
      rsp_ready = 1'b1;
    end
  endtask

  task automatic fetch1(input string nm, input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ee);
    step();
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    #1 chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    #1 chk({nm, "_early"}, {31'b0, rsp_valid}, 32'd0);
    step();
    #1;
    chk({nm, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({nm, "_instr"}, rsp_instr, ei);
    chk({nm, "_err"},   {30'b0, rsp_err}, {30'b0, ee});
    chk({nm, "_addr"},  rsp_addr, a);
  endtask

  initial begin
    int n_acc, n_rdy, n_vld, n_rsp, r;
    logic [31:0] last_addr;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(); step();
    rst = 1'b0;

    // Program image: word i holds 0x1000_0000+i, except word 4.
    for (int i = 0; i < 64; i++) begin
      step();
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + i;
    end
    idle(2);

    fetch1("single", 32'h10, 32'hDEAD_BEEF, 2'd0);
    idle(3);
    fetch1("misalign", 32'h2, 32'h0000_0013, 2'd1);
    idle(3);
    fetch1("range", 4 * DEPTH, 32'h0000_0013, 2'd2);
    idle(3);
    fetch1("misalign_hi", 4 * DEPTH + 3, 32'h0000_0013, 2'd1);
    idle(3);

    // Streaming: 16 back-to-back fetches, responses on 16 consecutive cycles.
    n_rdy = 0; n_vld = 0;
    for (int k = 0; k < 18; k++) begin
      step();
      req_valid = (k < 16);
      req_addr  = 32'(4 * k);
      rsp_ready = 1'b1;
      #1;
      if (k < 16 && req_ready) n_rdy++;
      if (k >= 2 && rsp_valid) n_vld++;
    end
    chk("stream_ready_cycles", n_rdy, 16);
    chk("stream_rsp_cycles", n_vld, 16);
    idle(4);

    // Backpressure: only FIFO_DEPTH accepts, one pop frees a slot next cycle.
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      req_valid = 1'b1;
      req_addr  = 32'h40 + 32'(4 * n_acc);
      rsp_ready = 1'b0;
      #1;
      if (req_ready) n_acc++;
    end
    chk("bp_accepts", n_acc, FD);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("bp_stalled", {31'b0, req_ready}, 32'd0);
    step();
    rsp_ready = 1'b0;
    #1 chk("bp_reopen", {31'b0, req_ready}, 32'd1);
    idle(8);

    // Flush with three in flight plus a redirect fetch at 0x80.
    for (int k = 0; k < 3; k++) begin
      step();
      req_valid = 1'b1;
      req_addr  = 32'(4 * k);
      rsp_ready = 1'b0;
    end
    step();
    flush    = 1'b1;
    req_addr = 32'h80;
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    #1 chk("flush_outstanding", 32'(dut.outstanding_q), 32'd1);
    rsp_ready = 1'b1;
    n_rsp = 0; last_addr = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      #1;
      if (rsp_valid) begin
        n_rsp++;
        last_addr = rsp_addr;
      end
    end
    chk("flush_rsp_count", n_rsp, 1);
    chk("flush_rsp_addr", last_addr, 32'h80);
    idle(3);

    // Same-word write and fetch: old data comes back, new data afterwards.
    step();
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'h1;
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    step();
    #1 chk("rbw_old", rsp_instr, 32'h1000_0000);
    idle(2);
    fetch1("rbw_new", 32'h0, 32'h1, 2'd0);
    idle(3);

    // Asynchronous reset with two outstanding fetches.
    step();
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
    step();
    req_addr = 32'h8;
    step();
    req_valid = 1'b0;
    #1 chk("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_ready", {31'b0, req_ready}, 32'd0);
    chk("arst_instr", rsp_instr, 32'd0);
    chk("arst_addr",  rsp_addr, 32'd0);
    step(); step();
    rst = 1'b0;
    #1 chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step();
      req_valid = ($urandom % 4) != 0;
      r = $urandom % 100;
      if (r < 80)      req_addr = 32'(($urandom % 64) * 4);
      else if (r < 90) req_addr = 32'(($urandom % 64) * 4 + 1 + ($urandom % 3));
      else             req_addr = ($urandom_range(32'h3FFF_FFFF, DEPTH) << 2) | (($urandom % 2) ? 32'($urandom % 4) : 32'h0);
      rsp_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 32) == 0;
      wr_en     = ($urandom % 10) == 0;
      wr_addr   = AW'($urandom % 64);
      wr_data   = $urandom;
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the far end of the fetch interface driven by the program counter. It accepts word-aligned fetch addresses over a valid/ready request channel and returns instruction words over a valid/ready response channel. Responses arrive in order after a fixed pipeline latency and pass through a small response FIFO. A credit counter bounds outstanding fetches, a flush input discards wrong-path fetches on redirect, and a write port loads the program image.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to earliest `o_rsp_valid`; range 1..4.
- `FIFO_DEPTH`, 4: response FIFO entries and maximum outstanding fetches; power of two, at least `LATENCY`+1.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_req_valid`  in  1  fetch request valid.
- `o_req_ready`  out  1  request can be accepted.
- `i_req_addr`  in  32  byte address, i.e. the PC value.
- `o_rsp_valid`  out  1  response valid (head of FIFO).
- `i_rsp_ready`  in  1  consumer takes the response.
- `o_rsp_instr`  out  32  instruction word.
- `o_rsp_err`  out  2  error code, `imem_pkg::err_e`.
- `o_rsp_addr`  out  32  address of the request this response answers.
- `i_flush`  in  1  discard all in-flight and buffered fetches.
- `i_wr_en`  in  1  program-load write strobe.
- `i_wr_addr`  in  $clog2(DEPTH)  word index to write.
- `i_wr_data`  in  32  word to write.

## Operation
- **Accept.** A request is accepted when `i_req_valid && o_req_ready`.
- **Ready.** `o_req_ready = !i_rst && (outstanding < FIFO_DEPTH)`. Here `outstanding` counts requests in the pipeline plus requests in the FIFO. There is no same-cycle bypass from a response pop.
- **Outstanding counter.** +1 on accept, −1 on response handshake, net 0 when both occur. Width is $clog2(FIFO_DEPTH)+1. The counter must never exceed `FIFO_DEPTH`, so the FIFO never overflows.
- **Error classification** is done at acceptance, with misalignment taking priority:
  - `addr[1:0] != 0` gives `ERR_MISALIGN`.
  - `addr[31:2] >= DEPTH` gives `ERR_RANGE`.
  - Otherwise `ERR_NONE`.
- **Error responses.** On any error, `o_rsp_instr = imem_pkg::NOP` (`32'h0000_0013`) and no memory read is used.
- **Memory read.** The read is sampled in the accept cycle. When a write and an accept target the same word in the same cycle, the read returns the old data (read-before-write).
- **Response handshake.** A response completes when `o_rsp_valid && i_rsp_ready`. Responses are strictly in acceptance order. Held outputs stay stable while `o_rsp_valid && !i_rsp_ready`.
- **Flush** (`i_flush=1`) at a clock edge:
  - All pipeline-stage valids and all FIFO entries are cleared.
  - `outstanding` becomes 0, or 1 if a request is accepted in the same cycle. A request accepted in the flush cycle is the redirect target and is kept.
  - A response handshake in the flush cycle completes normally before the discard.
- **Writes.** `i_wr_en` writes `mem[i_wr_addr]` at the edge. Writes are independent of both channels and of flush.

## Timing
- **Reset values** while `i_rst` is asserted: `o_req_ready=0`, `o_rsp_valid=0`, `o_rsp_instr=0`, `o_rsp_err=ERR_NONE`, `o_rsp_addr=0`; FIFO pointers 0; `outstanding=0`; stage valids 0. Memory contents are not reset.
- **Reset mid-operation.** All in-flight fetches are lost. `o_req_ready` rises in the first cycle after deassertion.
- **Latency.** A request accepted in cycle T with an empty FIFO gives `o_rsp_valid=1` in cycle T+`LATENCY`.
- **Throughput.** One fetch per cycle is sustained while `i_rsp_ready=1`.
- **Backpressure.** With `i_rsp_ready=0`, exactly `FIFO_DEPTH` requests are accepted, then `o_req_ready=0`. It returns to 1 in the cycle after the first response handshake.
- **Wrap-around.** FIFO pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Structure
- **Package `imem_pkg`:**
  - `typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_RANGE} err_e`
  - `localparam logic [31:0] NOP = 32'h0000_0013`
  - packed struct `rsp_t {instr, err, addr}`
- **Sub-module `sync_fifo`.** Parameterised width and depth, with push, pop, flush, full, empty and count. It is instantiated once for `rsp_t`.
- **Top level** holds the memory array, the `LATENCY`−1 stage pipeline and the credit counter.

## Test plan
- **Reset and single fetch.** Release reset, load `mem[4]=32'hDEADBEEF`, request addr `0x10` → `o_rsp_valid` high exactly 2 cycles later with instr `DEADBEEF`, err `ERR_NONE`, addr `0x10`.
- **Streaming.** Back-to-back requests `0x0,0x4,…,0x3C` with `i_rsp_ready=1` → 16 responses on 16 consecutive cycles, in order, with no ready drop.
- **Backpressure.** With `i_rsp_ready=0`, 4 requests accepted, the 5th stalls (`o_req_ready=0`) → one pop re-raises ready the next cycle; order is preserved.
- **Errors.** Addr `0x2` → `ERR_MISALIGN` with NOP. Addr `4*DEPTH` → `ERR_RANGE` with NOP. Addr `0x3` beyond range → `ERR_MISALIGN`.
- **Flush.** Flush with 3 outstanding plus a new request at `0x80` in the same cycle → only the `0x80` response emerges, and `outstanding` reads 1.
- **Same-word write and reset mid-operation.**
  - Write `mem[0]=1` while fetching `0x0` in the same cycle → the response returns the old value.
  - Assert `i_rst` with 2 outstanding → all outputs return to their reset values asynchronously.
